// File: rtl/einstein_int_pkg.sv
// Shared types and sizes for the Einstein Z80 mode-2 interrupt controller.
// Optional feature macro used by the controller: INTC_NESTING_EN.
package einstein_int_pkg;

    localparam int NUM_IRQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/intc_prio_enc.sv
// Combinational lowest-index-wins priority encoder with a valid flag.
module intc_prio_enc
    import einstein_int_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/einstein_int_ctrl.sv
// Eight-source Z80 mode-2 interrupt controller: edge latch, mask, priority, vector, in-service tracking.
// Define INTC_NESTING_EN to let a higher-priority source interrupt a lower one already in service.
module einstein_int_ctrl
    import einstein_int_pkg::*;
#(
    parameter logic [7:0] VECTOR_BASE  = 8'h00,
    parameter logic [7:0] SPURIOUS_VEC = 8'hFE
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_n,
    input  logic [NUM_IRQ-1:0] mask,
    input  logic               m1_n,
    input  logic               iorq_n,
    input  logic               reti,
    output logic               int_n,
    output logic [7:0]         vector_out,
    output logic               vector_oe,
    output logic [NUM_IRQ-1:0] ipend,
    output logic [NUM_IRQ-1:0] isr,
    output logic [1:0]         state_dbg
);

    // Handshake: the CPU acknowledges by holding M1 and IORQ low together; the vector
    // is latched on the first such cycle and vector_oe stays high until either rises.

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] irq_q, irq_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] isr_q, isr_d;
    logic               int_n_q, int_n_d;
    logic [7:0]         vector_out_q, vector_out_d;
    logic               vector_oe_q, vector_oe_d;
    logic               ack_q, ack_d;

    logic               ack;
    logic               ack_rise;
    logic [NUM_IRQ-1:0] edges;
    logic [NUM_IRQ-1:0] above;
    logic [NUM_IRQ-1:0] elig;
    logic [IDX_W-1:0]   win_idx;
    logic               win_valid;
    logic [IDX_W-1:0]   isr_idx;
    logic               isr_valid;
    logic [NUM_IRQ-1:0] isr_set;
    logic [NUM_IRQ-1:0] pend_clr;
    logic [NUM_IRQ-1:0] reti_clr;

    assign ack      = !m1_n && !iorq_n;
    assign ack_rise = ack && !ack_q;
    assign ack_d    = ack;
    assign irq_d    = irq_n;
    assign edges    = irq_q & ~irq_n;

    intc_prio_enc u_win_enc (
        .req   (elig),
        .idx   (win_idx),
        .valid (win_valid)
    );

    intc_prio_enc u_isr_enc (
        .req   (isr_q),
        .idx   (isr_idx),
        .valid (isr_valid)
    );

    always_comb begin
        above = '1;
        if (isr_valid) begin
`ifdef INTC_NESTING_EN
            above = (NUM_IRQ'(1) << isr_idx) - NUM_IRQ'(1);
`else
            above = '0;
`endif
        end
    end

    assign elig     = pending_q & mask & above;
    assign reti_clr = (reti && isr_valid) ? (NUM_IRQ'(1) << isr_idx) : '0;

    always_comb begin
        state_d      = state_q;
        int_n_d      = 1'b1;
        vector_out_d = vector_out_q;
        vector_oe_d  = 1'b0;
        isr_set      = '0;
        pend_clr     = '0;
        unique case (state_q)
            IDLE, REQ: begin
                if (ack_rise) begin
                    state_d     = ACK;
                    vector_oe_d = 1'b1;
                    if (win_valid) begin
                        vector_out_d      = VECTOR_BASE | {4'b0000, win_idx, 1'b0};
                        isr_set[win_idx]  = 1'b1;
                        pend_clr[win_idx] = 1'b1;
                    end else begin
                        vector_out_d = SPURIOUS_VEC;
                    end
                end else if (elig != '0) begin
                    state_d = REQ;
                    int_n_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                if (ack) begin
                    vector_oe_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // RETI clears before the new in-service bit lands; a fresh edge beats the ack clear.
        isr_d     = (isr_q & ~reti_clr) | isr_set;
        pending_d = (pending_q & ~pend_clr) | edges;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= IDLE;
            irq_q        <= '1;
            pending_q    <= '0;
            isr_q        <= '0;
            int_n_q      <= 1'b1;
            vector_out_q <= 8'h00;
            vector_oe_q  <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            irq_q        <= irq_d;
            pending_q    <= pending_d;
            isr_q        <= isr_d;
            int_n_q      <= int_n_d;
            vector_out_q <= vector_out_d;
            vector_oe_q  <= vector_oe_d;
            ack_q        <= ack_d;
        end
    end

    assign int_n      = int_n_q;
    assign vector_out = vector_out_q;
    assign vector_oe  = vector_oe_q;
    assign ipend      = pending_q;
    assign isr        = isr_q;
    assign state_dbg  = state_q;

endmodule
